// File: rtl/systolic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_pkg
// Purpose : Shared definitions for the systolic array controller slice:
//           default geometry, the controller state enum, and a helper that
//           sizes the controller counters.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package systolic_ctrl_pkg;

    localparam int DEFAULT_DATAWIDTH = 16;
    localparam int DEFAULT_N_SIZE    = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_FEED  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } systolic_state_e;

    // One counter width covers both the load index (0..N-1) and the feed
    // step (0..2N-2).
    function automatic int cnt_width(input int n_size);
        return $clog2(2 * n_size);
    endfunction

endpackage : systolic_ctrl_pkg

// File: rtl/systolic_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_if
// Purpose : Load and result bus of the systolic array controller.
// Signals : in_valid/in_ready   load beat handshake
//           in_a_row/in_b_row   row k of A and B on beat k
//           out_valid/out_ready result handshake
//           out_c               N x N result matrix, out_c[i][j] = C[i][j]
// Handshake: a transfer happens on a rising clock edge where valid and ready
//           are both 1. The source holds its data stable while valid is high
//           and ready is low; ready may be asserted independently of valid.
// Modports: master = job source / result sink, slave = controller.
// ---------------------------------------------------------------------------
interface systolic_ctrl_if #(
    parameter int DATAWIDTH = systolic_ctrl_pkg::DEFAULT_DATAWIDTH,
    parameter int N_SIZE    = systolic_ctrl_pkg::DEFAULT_N_SIZE
);
    logic                                          in_valid;
    logic                                          in_ready;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]              in_a_row;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]              in_b_row;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [N_SIZE-1:0][N_SIZE-1:0][2*DATAWIDTH-1:0] out_c;

    modport master (
        output in_valid, in_a_row, in_b_row, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_a_row, in_b_row, out_ready,
        output in_ready, out_valid, out_c
    );
endinterface : systolic_ctrl_if

// File: rtl/systolic_ctrl_skew.sv
// ---------------------------------------------------------------------------
// systolic_skew
// Purpose : Turns the stored A/B matrices and the feed step t into the
//           diagonally skewed edge feeds of an N x N systolic array:
//             o_arr_a[i] = A[i][t-i], o_arr_b[j] = B[t-j][j]
//           with 0 where the index falls outside 0..N-1, and all zeros when
//           i_feed_en is low. Inputs are registers only, so there is no path
//           from the controller's load ports.
// Ports   : i_feed_en  feed window active
//           i_t        feed step counter
//           i_a_buf    A, i_a_buf[row][col]
//           i_b_buf    B, i_b_buf[row][col]
//           o_arr_a    row feeds (one per array row)
//           o_arr_b    column feeds (one per array column)
// ---------------------------------------------------------------------------
module systolic_skew
    import systolic_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int N_SIZE    = DEFAULT_N_SIZE,
    parameter int CW        = cnt_width(DEFAULT_N_SIZE)
) (
    input  logic                                     i_feed_en,
    input  logic [CW-1:0]                            i_t,
    input  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] i_a_buf,
    input  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] i_b_buf,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]         o_arr_a,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]         o_arr_b
);

    localparam int IW = $clog2(N_SIZE);

    always_comb begin
        int w_k;
        w_k     = 0;
        o_arr_a = '0;
        o_arr_b = '0;
        if (i_feed_en) begin
            for (int i = 0; i < N_SIZE; i++) begin
                // Lane i runs i steps behind lane 0.
                w_k = int'(i_t) - i;
                if (w_k >= 0 && w_k < N_SIZE) begin
                    o_arr_a[i] = i_a_buf[i][w_k[IW-1:0]];
                    o_arr_b[i] = i_b_buf[w_k[IW-1:0]][i];
                end
            end
        end
    end

endmodule : systolic_skew

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Purpose : Controller for an external N x N output-stationary systolic
//           array. Loads A and B row by row, clears the accumulators for one
//           cycle, streams skewed feeds for 2N-1 steps, drains for N cycles
//           and then presents the accumulator contents until consumed.
// Ports   : clk, rst_n    clock, asynchronous active-low reset
//           bus          load/result bus (systolic_ctrl_if.slave)
//           arr_a/arr_b  skewed feeds to the array
//           arr_clr_n    active-low accumulator clear (flop output)
//           arr_c        accumulator values from the array
//           busy         high whenever the controller is not IDLE
//           o_dbg_state  current controller state
// ---------------------------------------------------------------------------
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int N_SIZE    = DEFAULT_N_SIZE
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    systolic_ctrl_if.slave                                bus,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]              arr_a,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]              arr_b,
    output logic                                          arr_clr_n,
    input  logic [N_SIZE-1:0][N_SIZE-1:0][2*DATAWIDTH-1:0] arr_c,
    output logic                                          busy,
    output systolic_state_e                               o_dbg_state
);

    localparam int CW = cnt_width(N_SIZE);
    localparam int IW = $clog2(N_SIZE);

    localparam logic [CW-1:0] LAST_LOAD  = CW'(N_SIZE - 1);
    localparam logic [CW-1:0] LAST_FEED  = CW'(2 * N_SIZE - 2);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(N_SIZE - 1);

    systolic_state_e                              r_state;
    logic [CW-1:0]                                r_cnt;
    logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] r_a_buf;
    logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] r_b_buf;
    logic                                         r_in_ready;
    logic                                         r_out_valid;
    logic                                         r_busy;
    logic                                         r_clr_n;

    logic                                         w_feed_en;

    assign w_feed_en     = (r_state == ST_FEED);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = arr_c;
    assign busy          = r_busy;
    assign arr_clr_n     = r_clr_n;
    assign o_dbg_state   = r_state;

    // r_cnt is the load index in IDLE/LOAD, the feed step t in FEED and the
    // drain cycle count in DRAIN. The beat that leaves IDLE lands at index 0,
    // so LOAD is entered with index 1 pointing at the next free row.
    // Handshake outputs are registered and updated together with the state
    // transition so they always match the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a_buf     <= '0;
            r_b_buf     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_clr_n     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_buf[0] <= bus.in_a_row;
                        r_b_buf[0] <= bus.in_b_row;
                        r_cnt      <= CW'(1);
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (bus.in_valid) begin
                        r_a_buf[r_cnt[IW-1:0]] <= bus.in_a_row;
                        r_b_buf[r_cnt[IW-1:0]] <= bus.in_b_row;
                        if (r_cnt == LAST_LOAD) begin
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_clr_n    <= 1'b0;
                            r_state    <= ST_CLEAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_CLEAR: begin
                    r_cnt   <= '0;
                    r_clr_n <= 1'b1;
                    r_state <= ST_FEED;
                end

                ST_FEED: begin
                    if (r_cnt == LAST_FEED) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Lets the last products ripple to the far corner PE.
                ST_DRAIN: begin
                    if (r_cnt == LAST_DRAIN) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_clr_n     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    systolic_skew #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .CW        (CW)
    ) u_skew (
        .i_feed_en (w_feed_en),
        .i_t       (r_cnt),
        .i_a_buf   (r_a_buf),
        .i_b_buf   (r_b_buf),
        .o_arr_a   (arr_a),
        .o_arr_b   (arr_b)
    );

endmodule : systolic_ctrl

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
// Bench for systolic_ctrl (N_SIZE=2, DATAWIDTH=16) with a behavioural
// output-stationary PE array attached to the feed/accumulator ports.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;
    import systolic_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int N  = 2;
    localparam int RW = N * N * 2 * DW;

    typedef logic [N-1:0][N-1:0][DW-1:0]   mat_t;
    typedef logic [N-1:0][N-1:0][2*DW-1:0] res_t;

    typedef struct {
        mat_t a;
        mat_t b;
        res_t c;
        int   gap;
        int   hold;
        bit   early_ready;
        bit   trace_feed;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + array model ----------------
    systolic_ctrl_if #(.DATAWIDTH(DW), .N_SIZE(N)) bus ();

    logic [N-1:0][DW-1:0] arr_a;
    logic [N-1:0][DW-1:0] arr_b;
    logic                 arr_clr_n;
    res_t                 arr_c;
    logic                 busy;
    systolic_state_e      dbg_state;

    systolic_ctrl #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_clr_n   (arr_clr_n),
        .arr_c       (arr_c),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // PE(i,j): acc += a_in*b_in, forwards a to the right and b downwards.
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [DW-1:0] ain [N][N];
    logic [DW-1:0] bin [N][N];
    res_t          acc;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain[i][j] = arr_a[i];
                else        ain[i][j] = pa[i][j-1];
                if (i == 0) bin[i][j] = arr_b[j];
                else        bin[i][j] = pb[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !arr_clr_n) begin
            acc <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + ({16'b0, ain[i][j]} * {16'b0, bin[i][j]});
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                end
        end
    end

    assign arr_c = acc;

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int accept_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mat_t mk(input logic [DW-1:0] x00, input logic [DW-1:0] x01,
                                input logic [DW-1:0] x10, input logic [DW-1:0] x11);
        mat_t m;
        m[0][0] = x00; m[0][1] = x01; m[1][0] = x10; m[1][1] = x11;
        return m;
    endfunction

    function automatic res_t mkr(input logic [2*DW-1:0] x00, input logic [2*DW-1:0] x01,
                                 input logic [2*DW-1:0] x10, input logic [2*DW-1:0] x11);
        res_t r;
        r[0][0] = x00; r[0][1] = x01; r[1][0] = x10; r[1][1] = x11;
        return r;
    endfunction

    function automatic res_t matmul(input mat_t a, input mat_t b);
        res_t r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    r[i][j] = r[i][j] + ({16'b0, a[i][k]} * {16'b0, b[k][j]});
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  1'b1);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_busy"},      busy,          1'b0);
        check({tag, "_clr_n"},     arr_clr_n,     1'b1);
        check({tag, "_arr_a"},     arr_a,         '0);
        check({tag, "_arr_b"},     arr_b,         '0);
        check({tag, "_state"},     dbg_state,     ST_IDLE);
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic load_job(input mat_t a, input mat_t b, input int gap);
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a_row = a[k];
            bus.in_b_row = b[k];
            check("load_in_ready", bus.in_ready, 1'b1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_a_row = DW'($urandom_range(0, 16'hFFFF)) * 2'd1 + {DW'($urandom_range(0, 16'hFFFF)), 16'b0};
            bus.in_b_row = {DW'($urandom_range(0, 16'hFFFF)), DW'($urandom_range(0, 16'hFFFF))};
            if (k < N - 1) repeat (gap) @(negedge clk);
        end
        accept_cyc = cyc;
    endtask

    task automatic run_job(input vec_t v);
        int n;
        logic [2*DW-1:0] tr_a [6];
        logic [2*DW-1:0] tr_b [6];
        logic            tr_clr [6];
        logic [2*DW-1:0] ex_a [6];
        logic [2*DW-1:0] ex_b [6];
        logic            ex_clr [6];
        logic [RW-1:0]   got;
        logic [RW-1:0]   exp;
        ex_a   = '{32'h0, 32'h0000_0001, 32'h0003_0002, 32'h0004_0000, 32'h0, 32'h0};
        ex_b   = '{32'h0, 32'h0000_0005, 32'h0006_0007, 32'h0008_0000, 32'h0, 32'h0};
        ex_clr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        exp_q.push_back(v.c);
        if (v.early_ready) bus.out_ready = 1'b1;
        load_job(v.a, v.b, v.gap);

        n = 0;
        while (!bus.out_valid && n < 60) begin
            if (n < 6) begin
                tr_a[n]   = arr_a;
                tr_b[n]   = arr_b;
                tr_clr[n] = arr_clr_n;
            end
            check("run_busy", busy, 1'b1);
            check("run_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", bus.out_valid, 1'b1);
            bus.out_ready = 1'b0;
            return;
        end
        check("latency", cyc - accept_cyc, 3 * N);
        got = bus.out_c;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("result", got, exp);

        if (v.trace_feed) begin
            for (int t = 0; t < 6; t++) begin
                check($sformatf("feed_clr_n_%0d", t), tr_clr[t], ex_clr[t]);
                check($sformatf("feed_arr_a_%0d", t), tr_a[t], ex_a[t]);
                check($sformatf("feed_arr_b_%0d", t), tr_b[t], ex_b[t]);
            end
        end

        // In DONE: stall the consumer, offer a bogus load beat meanwhile.
        for (int h = 0; h < v.hold; h++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_out_c", bus.out_c, got);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_arr_a", arr_a, '0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_out_valid", bus.out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_in_ready", bus.in_ready, 1'b1);
        check("post_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- test ----------------
    vec_t vecs[4];
    vec_t rv;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a_row  = '0;
        bus.in_b_row  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        vecs[0] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), c: mkr(19, 22, 43, 50),
                    gap: 0, hold: 10, early_ready: 1'b0, trace_feed: 1'b1};
        vecs[1] = '{a: mk(1, 0, 0, 1), b: mk(9, 9, 9, 9), c: mkr(9, 9, 9, 9),
                    gap: 0, hold: 0, early_ready: 1'b0, trace_feed: 1'b0};
        vecs[2] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), c: mkr(19, 22, 43, 50),
                    gap: 2, hold: 0, early_ready: 1'b0, trace_feed: 1'b0};
        vecs[3] = '{a: mk(16'h8000, 16'h0001, 16'h0002, 16'h7FFF),
                    b: mk(16'h0003, 16'h8000, 16'hFFFF, 16'h0000),
                    c: mkr(32'h0002_7FFF, 32'h4000_0000, 32'h7FFE_8007, 32'h0001_0000),
                    gap: 1, hold: 0, early_ready: 1'b1, trace_feed: 1'b0};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Table jobs, back to back (job 1 follows job 0 directly after its handshake).
        for (int v = 0; v < 4; v++) run_job(vecs[v]);

        // Reset during FEED t=1, then a full job must still be correct.
        load_job(vecs[0].a, vecs[0].b, 0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_state", dbg_state, ST_FEED);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_feed_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_feed_release");
        run_job(vecs[0]);

        // Random jobs with random load gaps.
        for (int r = 0; r < 4; r++) begin
            rv.a = mk(DW'($urandom_range(0, 16'h7FFF)), DW'($urandom_range(0, 16'h7FFF)),
                      DW'($urandom_range(0, 16'h7FFF)), DW'($urandom_range(0, 16'h7FFF)));
            rv.b = mk(DW'($urandom_range(0, 16'h7FFF)), DW'($urandom_range(0, 16'h7FFF)),
                      DW'($urandom_range(0, 16'h7FFF)), DW'($urandom_range(0, 16'h7FFF)));
            rv.c           = matmul(rv.a, rv.b);
            rv.gap         = int'($urandom_range(0, 3));
            rv.hold        = int'($urandom_range(0, 2));
            rv.early_ready = 1'b0;
            rv.trace_feed  = 1'b0;
            run_job(rv);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends with a summary line.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_systolic_ctrl
